mod_port: RTL and testbench
===========================

// Module: mod_port
// PURPOSE
//  Destination-side output port of the 1x3 router. Buffers bytes from the router core in a FIFO.
//  Presents them to the destination on dout/vld_out, one byte per cycle while reen is high.
//  Flushes itself with a soft reset if the destination leaves valid data unread for TIMEOUT cycles.
// PARAMETERS
//  WIDTH    8   data byte width
//  DEPTH   16   FIFO depth in entries (power of 2)
//  TIMEOUT 30   cycles of vld_out=1 with reen=0 before soft reset
// PORTS
//  clk       in   1      single clock; all logic on posedge
//  rst       in   1      asynchronous, active-high reset
//  we        in   1      write enable from router core
//  din       in   WIDTH  write data (header, payload or parity byte)
//  lfd       in   1      din is a packet header byte; stored as entry bit WIDTH
//  reen      in   1      read enable from destination
//  dout      out  WIDTH  read data, registered
//  vld_out   out  1      FIFO holds unread data (= ~empty)
//  full      out  1      FIFO holds DEPTH entries
//  empty     out  1      FIFO holds 0 entries
//  soft_rst  out  1      one-cycle pulse: timeout flush occurred
// BEHAVIOUR
//  Clocking and reset
//  - One clock; reset is asynchronous and active-high.
//  - On rst: pointers=0, count=0, dout=0, soft_rst=0, timeout counter=0.
//  - Hence empty=1, full=0, vld_out=0.
//  Storage
//  - Memory holds DEPTH x (WIDTH+1) entries, each {lfd,din}.
//  - wr_ptr, rd_ptr: log2(DEPTH) bits, wrap DEPTH-1 -> 0.
//  - count: log2(DEPTH)+1 bits; full = (count==DEPTH), empty = (count==0).
//  Write and read
//  - Write: when we && !full, entry is stored at wr_ptr; wr_ptr++.
//  - Write with we && full is ignored; no state change.
//  - Read: when reen && !empty, dout <= mem[rd_ptr][WIDTH-1:0]; rd_ptr++.
//  - Read latency: dout is valid on the edge after reen is sampled high.
//  - Read with reen && empty is ignored; dout holds its last value.
//  - Simultaneous valid read and write: both occur; count is unchanged.
//  - Write while empty: vld_out rises the next cycle. A same-cycle read does not return that byte.
//  - full and empty are combinational from count. vld_out = ~empty.
//  Timeout and soft reset
//  - Timer increments each cycle with vld_out && !reen; otherwise it clears.
//  - When the timer reaches TIMEOUT-1 and the condition still holds, on that edge:
//    soft_rst=1 for one cycle; pointers, count and timer clear; dout=0.
//  - A write in the flush cycle is discarded.
//  - rst overrides soft reset at all times.
// TESTING
//  - Reset: rst=1 mid-stream -> dout=0, vld_out=0, empty=1, full=0 immediately (async).
//  - Write 0x0C (lfd=1), 0x11, 0x22, 0x33, 0x1E, then reen=1 for 5 cycles
//    -> dout 0x0C, 0x11, 0x22, 0x33, 0x1E on successive edges; vld_out=0 afterwards.
//  - Fill 16 bytes -> full=1; write 0xFF -> ignored; read 16 -> last byte is 16th written.
//  - Wrap: write/read 40 bytes with reen and we both high -> data in order, count stays constant.
//  - Timeout: write 1 byte, hold reen=0 -> soft_rst pulse after 30 cycles, empty=1, dout=0.
//  - Hold reen=0 for 29 cycles, then reen=1 -> no soft_rst; data read correctly.

Source files
------------

// File: rtl/mod_port_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_port_if
// Description : Handshake bundle between router core, output port and the
//               destination.
// Revision    : 1.0
// ============================================================================
interface mod_port_if #(
  parameter int WIDTH = 8
) ();
  logic             we;
  logic [WIDTH-1:0] din;
  logic             lfd;
  logic             reen;
  logic [WIDTH-1:0] dout;
  logic             vld_out;
  logic             full;
  logic             empty;
  logic             soft_rst;

  modport master (
    output we, din, lfd, reen,
    input  dout, vld_out, full, empty, soft_rst
  );

  modport slave (
    input  we, din, lfd, reen,
    output dout, vld_out, full, empty, soft_rst
  );
endinterface
`default_nettype wire

// File: rtl/mod_port.sv
`default_nettype none
// ============================================================================
// Module      : mod_port
// Description : Router output port. FIFO buffer with registered read data and
//               a stall timeout that flushes the port with a soft reset.
// Revision    : 1.0
// ============================================================================
module mod_port #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  wire logic     clk,
  input  wire logic     rst,
  mod_port_if.slave     bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] C_TMR_MAX  = TW'(TIMEOUT - 1);

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [TW-1:0]    timer_q,  timer_d;
  logic [WIDTH-1:0] dout_q,   dout_d;
  logic             soft_rst_q, soft_rst_d;

  logic full_w;
  logic empty_w;
  logic wr_en;
  logic rd_en;
  logic stall;
  logic flush;
  logic mem_we;

  assign full_w  = (count_q == C_FULL_CNT);
  assign empty_w = (count_q == '0);
  assign wr_en   = bus.we   && !full_w;
  assign rd_en   = bus.reen && !empty_w;
  assign stall   = !empty_w && !bus.reen;
  assign flush   = stall && (timer_q == C_TMR_MAX);
  // A write landing in the flush cycle is dropped along with the contents.
  assign mem_we  = wr_en && !flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    timer_d    = timer_q;
    dout_d     = dout_q;
    soft_rst_d = 1'b0;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      timer_d    = '0;
      dout_d     = '0;
      soft_rst_d = 1'b1;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        dout_d   = mem_q[rd_ptr_q][WIDTH-1:0];
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      timer_d = stall ? (timer_q + TW'(1)) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      dout_q     <= '0;
      soft_rst_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      dout_q     <= dout_d;
      soft_rst_q <= soft_rst_d;
    end
  end

  // Storage array carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= {bus.lfd, bus.din};
    end
  end

  assign bus.dout     = dout_q;
  assign bus.vld_out  = !empty_w;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.soft_rst = soft_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_port
// Description : Directed, table-driven bench for the router output port.
// Revision    : 1.0
// ============================================================================
module tb_mod_port;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mod_port_if #(.WIDTH(8)) bus ();

  mod_port #(.WIDTH(8), .DEPTH(16), .TIMEOUT(30)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] din;
    logic       lfd;
    logic       reen;
    logic [7:0] e_dout;
    logic       e_vld;
    logic       e_full;
    logic       e_empty;
    logic       e_soft;
  } vec_t;

  vec_t       vecs [14];
  logic [7:0] model [$];
  logic [7:0] exp_b;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [7:0] din, input logic lfd, input logic reen);
    bus.we   = we;
    bus.din  = din;
    bus.lfd  = lfd;
    bus.reen = reen;
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // {we, din, lfd, reen, dout, vld, full, empty, soft}
    vecs[0]  = '{1'b1, 8'h0C, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h1E, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h0C, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h1E, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h1E, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 8'hAA, 1'b0, 1'b1, 8'h1E, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'hBB, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b0};

    // Power-on reset
    step();
    step();
    check("reset dout",  32'(bus.dout),     32'h00);
    check("reset vld",   32'(bus.vld_out),  32'h0);
    check("reset empty", 32'(bus.empty),    32'h1);
    check("reset full",  32'(bus.full),     32'h0);
    check("reset soft",  32'(bus.soft_rst), 32'h0);
    rst = 1'b0;
    step();

    // Table-driven basic traffic
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].we, vecs[i].din, vecs[i].lfd, vecs[i].reen);
      step();
      check($sformatf("vec%0d dout", i),  32'(bus.dout),     32'(vecs[i].e_dout));
      check($sformatf("vec%0d vld", i),   32'(bus.vld_out),  32'(vecs[i].e_vld));
      check($sformatf("vec%0d full", i),  32'(bus.full),     32'(vecs[i].e_full));
      check($sformatf("vec%0d empty", i), 32'(bus.empty),    32'(vecs[i].e_empty));
      check($sformatf("vec%0d soft", i),  32'(bus.soft_rst), 32'(vecs[i].e_soft));
    end

    // Asynchronous reset mid-stream
    drive(1'b1, 8'h5C, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h6D, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    check("pre-rst dout", 32'(bus.dout), 32'h5C);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async rst dout",  32'(bus.dout),    32'h00);
    check("async rst vld",   32'(bus.vld_out), 32'h0);
    check("async rst empty", 32'(bus.empty),   32'h1);
    check("async rst full",  32'(bus.full),    32'h0);
    step();
    rst = 1'b0;
    step();

    // Fill to full, overflow write, drain
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(32'h40 + i), (i == 0), 1'b0);
      step();
    end
    check("fill full", 32'(bus.full), 32'h1);
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    step();
    check("overflow full", 32'(bus.full), 32'h1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      step();
      check($sformatf("drain%0d dout", i), 32'(bus.dout), 32'h40 + 32'(i));
      if (i == 0) check("drain0 full", 32'(bus.full), 32'h0);
    end
    check("drain empty", 32'(bus.empty), 32'h1);

    // Wrap with simultaneous read and write
    model.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(32'h90 + i), 1'b0, 1'b0);
      model.push_back(8'(32'h90 + i));
      step();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'(32'hA0 + i), 1'b0, 1'b1);
      exp_b = model.pop_front();
      model.push_back(8'(32'hA0 + i));
      step();
      check($sformatf("wrap%0d dout", i), 32'(bus.dout), 32'(exp_b));
      check($sformatf("wrap%0d vld", i),  32'(bus.vld_out), 32'h1);
      check($sformatf("wrap%0d full", i), 32'(bus.full), 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      exp_b = model.pop_front();
      step();
      check($sformatf("wrapdrain%0d dout", i), 32'(bus.dout), 32'(exp_b));
    end
    check("wrap empty", 32'(bus.empty), 32'h1);

    // Timeout flush, with a write presented in the flush cycle
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 29; k++) begin
      step();
      if (bus.soft_rst !== 1'b0) check($sformatf("tmo early soft k%0d", k), 32'(bus.soft_rst), 32'h0);
    end
    check("tmo vld before flush", 32'(bus.vld_out), 32'h1);
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    step();
    check("tmo soft",  32'(bus.soft_rst), 32'h1);
    check("tmo empty", 32'(bus.empty),    32'h1);
    check("tmo dout",  32'(bus.dout),     32'h00);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check("tmo soft pulse", 32'(bus.soft_rst), 32'h0);
    check("tmo write dropped", 32'(bus.empty), 32'h1);

    // Stall just under the limit, then read
    drive(1'b1, 8'h6B, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 29; k++) begin
      step();
      if (bus.soft_rst !== 1'b0) check($sformatf("near soft k%0d", k), 32'(bus.soft_rst), 32'h0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    check("near dout",  32'(bus.dout),     32'h6B);
    check("near soft",  32'(bus.soft_rst), 32'h0);
    check("near empty", 32'(bus.empty),    32'h1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check("near soft after", 32'(bus.soft_rst), 32'h0);
    check("near dout hold",  32'(bus.dout),     32'h6B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
